// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: burst operand pair generator with Wfull back-pressure and a golden product-average model for the MAC.
module mac_operand_sequencer #(
    parameter logic [7:0] LFSR_TAPS = 8'hB8,
    parameter int         GROUP     = 4
) (
    input  logic       Wclk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       Mode,
    input  logic [7:0] Seed,
    input  logic [7:0] BurstLen,
    input  logic       Wfull,
    output logic [3:0] DataIn1,
    output logic [3:0] DataIn2,
    output logic       Wen,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] ExpAvg,
    output logic       ExpValid,
    output logic [8:0] SentCount
);
    localparam int LG = $clog2(GROUP);
    localparam logic [LG-1:0] GLAST = LG'(GROUP - 1);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t        state;
    logic [7:0]    pattern;
    logic          mode;
    logic [8:0]    remaining;
    logic [LG-1:0] grp;
    logic [11:0]   sum;
    logic          xfer;
    logic [7:0]    prod;
    logic [7:0]    next_pat;
    logic [11:0]   sum_next;
    assign xfer     = Wen && !Wfull;
    assign prod     = {4'd0, pattern[7:4]} * {4'd0, pattern[3:0]};
    assign sum_next = sum + {4'd0, prod};
    assign next_pat = mode ? {pattern[6:0], ^(pattern & LFSR_TAPS)} : pattern + 8'd1;
    assign DataIn1  = pattern[7:4];
    assign DataIn2  = pattern[3:0];
    always_ff @(posedge Wclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pattern   <= 8'd0;
            mode      <= 1'b0;
            remaining <= 9'd0;
            grp       <= '0;
            sum       <= 12'd0;
            Wen       <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ExpAvg    <= 8'd0;
            ExpValid  <= 1'b0;
            SentCount <= 9'd0;
        end else begin
            Done     <= 1'b0;
            ExpValid <= 1'b0;
            case (state)
                IDLE: if (Start) begin
                    mode      <= Mode;
                    pattern   <= (Mode && Seed == 8'd0) ? 8'h01 : Seed;
                    remaining <= (BurstLen == 8'd0) ? 9'd256 : {1'b0, BurstLen};
                    SentCount <= 9'd0;
                    grp       <= '0;
                    sum       <= 12'd0;
                    Wen       <= 1'b1;
                    Busy      <= 1'b1;
                    state     <= SEND;
                end
                SEND: if (xfer) begin
                    SentCount <= SentCount + 9'd1;
                    remaining <= remaining - 9'd1;
                    pattern   <= next_pat;
                    // group closes on the same edge that carries its last product
                    if (grp == GLAST) begin
                        ExpAvg   <= 8'(sum_next >> LG);
                        ExpValid <= 1'b1;
                        sum      <= 12'd0;
                        grp      <= '0;
                    end else begin
                        sum <= sum_next;
                        grp <= grp + 1'b1;
                    end
                    if (remaining == 9'd1) begin
                        Wen   <= 1'b0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed scenario tasks for mac_operand_sequencer.
module tb_mac_operand_sequencer;
    logic       Wclk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic       Mode = 1'b0;
    logic [7:0] Seed = 8'd0;
    logic [7:0] BurstLen = 8'd0;
    logic       Wfull = 1'b0;
    logic [3:0] DataIn1, DataIn2;
    logic       Wen, Busy, Done, ExpValid;
    logic [7:0] ExpAvg;
    logic [8:0] SentCount;
    logic [7:0] pair;
    int total = 0;
    int bad = 0;

    mac_operand_sequencer dut (
        .Wclk(Wclk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode), .Seed(Seed),
        .BurstLen(BurstLen), .Wfull(Wfull), .DataIn1(DataIn1), .DataIn2(DataIn2),
        .Wen(Wen), .Busy(Busy), .Done(Done), .ExpAvg(ExpAvg), .ExpValid(ExpValid),
        .SentCount(SentCount)
    );

    assign pair = {DataIn1, DataIn2};
    always #5 Wclk = ~Wclk;

    task automatic step();
        @(posedge Wclk);
        #1;
    endtask

    task automatic start_burst(input logic m, input logic [7:0] s, input logic [7:0] l);
        Start = 1'b1;
        Mode = m;
        Seed = s;
        BurstLen = l;
        step();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({pair, Wen, Busy, Done, ExpAvg, ExpValid, SentCount} !== 31'd0) begin
            bad++;
            $display("FAIL reset_por got=%0h want=0", {pair, Wen, Busy, Done, ExpAvg, ExpValid, SentCount});
        end
        #20 Reset_n = 1'b1;
        step();
        start_burst(1'b0, 8'h55, 8'd10);
        step();
        step();
        total++;
        if (SentCount !== 9'd2 || pair !== 8'h57) begin
            bad++;
            $display("FAIL reset_preburst got=%0d/%0h want=2/57", SentCount, pair);
        end
        #3 Reset_n = 1'b0;
        #1;
        total++;
        if ({pair, Wen, Busy, Done, ExpAvg, ExpValid, SentCount} !== 31'd0) begin
            bad++;
            $display("FAIL reset_async got=%0h want=0", {pair, Wen, Busy, Done, ExpAvg, ExpValid, SentCount});
        end
        #2 Reset_n = 1'b1;
        step();
        total++;
        if (Wen !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || SentCount !== 9'd0) begin
            bad++;
            $display("FAIL reset_no_resume got=%b%b%b/%0d want=000/0", Wen, Busy, Done, SentCount);
        end
    endtask

    task automatic test_incr();
        start_burst(1'b0, 8'h11, 8'd4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (Wen !== 1'b1 || pair !== 8'(8'h11 + i)) begin
                bad++;
                $display("FAIL incr_pair%0d got=%b/%0h want=1/%0h", i, Wen, pair, 8'(8'h11 + i));
            end
            step();
        end
        total++;
        if (Done !== 1'b1 || ExpValid !== 1'b1 || ExpAvg !== 8'd2 || SentCount !== 9'd4 || Wen !== 1'b0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL incr_end got=D%b V%b avg%0d n%0d W%b B%b want=D1 V1 avg2 n4 W0 B0", Done, ExpValid, ExpAvg, SentCount, Wen, Busy);
        end
        step();
        total++;
        if (Done !== 1'b0 || ExpValid !== 1'b0 || ExpAvg !== 8'd2 || SentCount !== 9'd4) begin
            bad++;
            $display("FAIL incr_after got=D%b V%b avg%0d n%0d want=D0 V0 avg2 n4", Done, ExpValid, ExpAvg, SentCount);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pair [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        start_burst(1'b0, 8'hFE, 8'd4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pair !== exp_pair[i]) begin
                bad++;
                $display("FAIL wrap_pair%0d got=%0h want=%0h", i, pair, exp_pair[i]);
            end
            step();
        end
        total++;
        if (Done !== 1'b1 || ExpValid !== 1'b1 || ExpAvg !== 8'd108) begin
            bad++;
            $display("FAIL wrap_avg got=D%b V%b avg%0d want=D1 V1 avg108", Done, ExpValid, ExpAvg);
        end
        step();
    endtask

    task automatic test_stall();
        start_burst(1'b0, 8'h11, 8'd4);
        step();
        step();
        Wfull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (Wen !== 1'b1 || pair !== 8'h13 || SentCount !== 9'd2) begin
                bad++;
                $display("FAIL stall_hold%0d got=%b/%0h/%0d want=1/13/2", i, Wen, pair, SentCount);
            end
        end
        Wfull = 1'b0;
        step();
        total++;
        if (pair !== 8'h14 || SentCount !== 9'd3) begin
            bad++;
            $display("FAIL stall_resume got=%0h/%0d want=14/3", pair, SentCount);
        end
        step();
        total++;
        if (Done !== 1'b1 || ExpValid !== 1'b1 || ExpAvg !== 8'd2 || SentCount !== 9'd4) begin
            bad++;
            $display("FAIL stall_end got=D%b V%b avg%0d n%0d want=D1 V1 avg2 n4", Done, ExpValid, ExpAvg, SentCount);
        end
        step();
    endtask

    task automatic test_len(input logic [7:0] len, input int want_n, input int want_ev, input logic [7:0] want_avg);
        int n = 0;
        int ev = 0;
        logic got_done = 1'b0;
        start_burst(1'b0, 8'h00, len);
        for (int c = 0; c < 400 && !got_done; c++) begin
            if (Wen) n++;
            step();
            if (ExpValid) ev++;
            if (Done) got_done = 1'b1;
        end
        total++;
        if (!got_done || n != want_n || ev != want_ev || SentCount !== 9'(want_n) || ExpAvg !== want_avg) begin
            bad++;
            $display("FAIL len%0d got=done%b n%0d ev%0d cnt%0d avg%0d want=done1 n%0d ev%0d cnt%0d avg%0d",
                     len, got_done, n, ev, SentCount, ExpAvg, want_n, want_ev, want_n, want_avg);
        end
        step();
    endtask

    task automatic test_start_ignored();
        start_burst(1'b0, 8'h31, 8'd4);
        Start = 1'b1;
        Mode = 1'b1;
        Seed = 8'h90;
        step();
        total++;
        if (pair !== 8'h32) begin
            bad++;
            $display("FAIL ign_pair1 got=%0h want=32", pair);
        end
        step();
        Start = 1'b0;
        total++;
        if (pair !== 8'h33 || SentCount !== 9'd2) begin
            bad++;
            $display("FAIL ign_pair2 got=%0h/%0d want=33/2", pair, SentCount);
        end
        step();
        step();
        total++;
        if (Done !== 1'b1 || SentCount !== 9'd4 || ExpAvg !== 8'd7) begin
            bad++;
            $display("FAIL ign_end got=D%b n%0d avg%0d want=D1 n4 avg7", Done, SentCount, ExpAvg);
        end
        step();
        step();
        total++;
        if (Wen !== 1'b0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_idle got=%b%b want=00", Wen, Busy);
        end
    endtask

    task automatic test_lfsr();
        logic [7:0] exp_pair [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        start_burst(1'b1, 8'h00, 8'd8);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (pair !== exp_pair[i]) begin
                bad++;
                $display("FAIL lfsr_pair%0d got=%0h want=%0h", i, pair, exp_pair[i]);
            end
            step();
            if (i == 3) begin
                total++;
                if (ExpValid !== 1'b1 || ExpAvg !== 8'd0 || Done !== 1'b0) begin
                    bad++;
                    $display("FAIL lfsr_grp1 got=V%b avg%0d D%b want=V1 avg0 D0", ExpValid, ExpAvg, Done);
                end
            end
        end
        total++;
        if (Done !== 1'b1 || ExpValid !== 1'b1 || ExpAvg !== 8'd36) begin
            bad++;
            $display("FAIL lfsr_grp2 got=D%b V%b avg%0d want=D1 V1 avg36", Done, ExpValid, ExpAvg);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_stall();
        test_len(8'd0, 256, 64, 8'd202);
        test_len(8'd6, 6, 1, 8'd0);
        test_start_ignored();
        test_lfsr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Write-side stimulus and golden-model stage that sits directly upstream of the MAC block in the Wclk domain.
- Generates a burst of 4-bit operand pairs (DataIn1, DataIn2) with a valid/back-pressure handshake against the MAC's Wfull flag.
- In parallel, computes the expected 4-sample product average (ExpAvg) for every complete group of four accepted pairs. Downstream checkers compare ExpAvg against AverageOut.

Parameters:
- LFSR_TAPS, 8'hB8, feedback mask for LFSR mode; bit i set means state[i] is XORed into feedback. Default taps are bits 7,5,4,3, polynomial x^8+x^6+x^5+x^4+1.
- GROUP, 4, pairs per average group; must be a power of 2, range 2..16.

Ports:
- Wclk  in  1  write-domain clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  burst request; sampled only in IDLE
- Mode  in  1  0 = increment pattern, 1 = LFSR pattern
- Seed  in  8  initial {DataIn1,DataIn2}
- BurstLen  in  8  pairs per burst; 0 means 256
- Wfull  in  1  back-pressure from the MAC write side
- DataIn1  out  4  operand A, upper nibble of pattern
- DataIn2  out  4  operand B, lower nibble of pattern
- Wen  out  1  pair valid
- Busy  out  1  burst in progress
- Done  out  1  one-cycle end-of-burst pulse
- ExpAvg  out  8  expected average of the last complete group
- ExpValid  out  1  one-cycle pulse when ExpAvg updates
- SentCount  out  9  pairs accepted in the current or last burst

Behaviour:
- Reset (Reset_n=0, asynchronous): every output is 0, state is IDLE, all internal counters are 0.
- Reset asserted mid-burst aborts the burst immediately. No Done pulse is generated. No partial ExpValid is generated.
- Transfer: occurs on a rising Wclk edge where Wen=1 and Wfull=0.
- While Wen=1 and Wfull=1, DataIn1, DataIn2 and Wen hold stable.
- State machine IDLE -> SEND -> DONE -> IDLE.
- IDLE:
  - Wen=0, Busy=0.
  - When Start=1 at an edge: latch Mode, Seed and BurstLen; load remaining = BurstLen (or 256 if 0); clear SentCount and the group counter.
  - The pattern register loads Seed. In LFSR mode, Seed=0 is replaced by 8'h01.
  - Move to SEND; Wen=1 from the cycle after Start is sampled.
- SEND:
  - Wen=1, Busy=1.
  - On each transfer: SentCount increments, remaining decrements, and the pattern advances.
  - If remaining was 1 at the transfer, go to DONE with Wen=0.
  - Start is ignored in SEND.
- DONE: Done=1 and Busy=0 for exactly one cycle, then IDLE. SentCount holds its value until the next accepted Start.
- Increment mode: next = pattern + 1, modulo 256 (8'hFF wraps to 8'h00).
- LFSR mode: next = {pattern[6:0], XOR-reduce(pattern & LFSR_TAPS)}.
- Golden model, evaluated on each transfer:
  - product = DataIn1*DataIn2, unsigned 8 bits, maximum 225.
  - product is added into a sum register of at least 12 bits.
  - The group counter increments.
  - On the GROUP-th transfer of a group, at the same edge: ExpAvg <= (sum including this product) >> log2(GROUP), truncated; ExpValid=1 for the next cycle only; sum and group counter clear.
- ExpAvg holds its value between updates.
- A partial group at burst end is discarded: no ExpValid, and sum clears on the next Start.
- Simultaneous events:
  - Last transfer completing a group: ExpValid and Done are high in the same cycle.
  - Wfull rising on the same edge as a would-be transfer: no transfer occurs; data holds.
- Wfull is treated as synchronous to Wclk. No internal synchronizer is required.

Test Plan:
- Reset: drive Reset_n=0 mid-burst with Wfull=0 -> all outputs 0 asynchronously, before the next edge. After release, Start is needed to resume.
- Incr, Seed=8'h11, BurstLen=4, Wfull=0:
  - Pairs 11, 12, 13, 14 on four consecutive cycles.
  - Products 1, 2, 3, 4 -> ExpAvg=2 with one ExpValid pulse, coincident with Done.
  - SentCount=4.
- Stall: same burst with Wfull=1 for 3 cycles after the 2nd transfer -> Wen stays 1 with pair held at 13; SentCount stays 2. Burst completes after release with ExpAvg=2.
- Wrap: Seed=8'hFE, BurstLen=4 -> pairs FE, FF, 00, 01. Products 210, 225, 0, 0 -> ExpAvg=108.
- Length edges:
  - BurstLen=0 -> 256 transfers, 64 ExpValid pulses, SentCount=256.
  - BurstLen=6 -> exactly 1 ExpValid pulse, Done after the 6th transfer.
  - Start pulsed during SEND -> ignored.
- LFSR, Seed=0 -> first pairs 01, 02, 04, 08, 11. ExpAvg of the first group = (0+0+0+0)>>2 = 0.
